booth_mul_iter: RTL

//  Parametrised iterative radix-4 Booth multiplier for the EXU MDU path. Produces the full
//  2*XLEN product (hi/lo) for signed/unsigned operand mixes plus RV64 MULW mode. It retires

---
 rtl/booth_mul_iter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the MDU path.
// Full 2*XLEN product, signed/unsigned mixes, RV64 MULW mode.
module booth_mul_iter #(
  parameter int XLEN  = 64,
  parameter int STEPS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int AW   = 2*XLEN + 2;
  localparam int YW   = AW + 1;
  localparam int DF   = XLEN/2 + 1;
  localparam int CF   = (DF + STEPS - 1) / STEPS;
  localparam int C32  = (17 + STEPS - 1) / STEPS;
  localparam int CNTW = $clog2(CF + 1);
  localparam int SH   = (XLEN > 32) ? XLEN - 32 : 0;
  localparam bit HAS_W = (XLEN == 64);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]   acc_q, mc_q;
  logic [YW-1:0]   y_q;
  logic [CNTW-1:0] cnt_q;
  logic            mulw_q;
  logic            mulw_e;
  logic            unused_top;

  logic [AW-1:0]   acc_n, mc_n, pp;
  logic [YW-1:0]   y_n;

  assign mulw_e     = mulw & HAS_W;
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign unused_top = ^acc_q[AW-1:2*XLEN];

  // Operand widened to accumulator width with sign or zero fill.
  function automatic logic [AW-1:0] ext(
    input logic [XLEN-1:0] v,
    input logic            sgn,
    input logic            w32
  );
    logic [AW-1:0] t;
    int            sh;
    sh = w32 ? AW - 32 : AW - XLEN;
    t  = {{(AW-XLEN){1'b0}}, v} << sh;
    if (sgn) ext = $signed(t) >>> sh;
    else     ext = t >> sh;
  endfunction

  always_comb begin
    acc_n = acc_q;
    mc_n  = mc_q;
    y_n   = y_q;
    pp    = '0;
    for (int s = 0; s < STEPS; s++) begin
      unique case (y_n[2:0])
        3'b001, 3'b010: pp = mc_n;
        3'b011:         pp = mc_n << 1;
        3'b100:         pp = -(mc_n << 1);
        3'b101, 3'b110: pp = -mc_n;
        default:        pp = '0;
      endcase
      acc_n = acc_n + pp;
      mc_n  = mc_n << 2;
      y_n   = {{2{y_n[YW-1]}}, y_n[YW-1:2]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && !flush) state_d = BUSY;
      BUSY: begin
        if (flush)                        state_d = IDLE;
        else if (cnt_q == CNTW'(1))       state_d = DONE;
      end
      DONE:    if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      mc_q   <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      mulw_q <= 1'b0;
    end else if (flush) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        acc_q  <= '0;
        mc_q   <= ext(multiplicand, mul_signed[1], mulw_e);
        y_q    <= {ext(multiplier, mul_signed[0], mulw_e), 1'b0};
        cnt_q  <= mulw_e ? CNTW'(C32) : CNTW'(CF);
        mulw_q <= mulw_e;
      end
    end else if (state_q == BUSY) begin
      acc_q <= acc_n;
      mc_q  <= mc_n;
      y_q   <= y_n;
      cnt_q <= cnt_q - CNTW'(1);
    end else if (out_ready) begin
      acc_q <= '0;
    end
  end

  always_comb begin
    result_hi = '0;
    result_lo = '0;
    if (state_q == DONE) begin
      if (mulw_q) begin
        result_lo = $signed(acc_q[XLEN-1:0] << SH) >>> SH;
      end else begin
        result_hi = acc_q[2*XLEN-1:XLEN];
        result_lo = acc_q[XLEN-1:0];
      end
    end
  end

endmodule
